// File: rtl/nat_conn_table.sv
// NAT connection table: beat-serialised flow key in, hashed into a 2^HASH_LEN slot table,
// bounded linear probing for lookup/insert/delete, one response per key.
module nat_conn_table #(
    parameter int BUS_W     = 32,
    parameter int KEY_W     = 104,
    parameter int HASH_LEN  = 10,
    parameter int MAX_PROBE = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tuple_valid_i,
    input  logic [BUS_W-1:0]    tuple_data_i,
    input  logic                tuple_op_i,
    output logic                tuple_ready_o,
    output logic                conn_valid_o,
    output logic [BUS_W-1:0]    conn_data_o,
    output logic [1:0]          conn_status_o,
    input  logic                conn_ready_i,
    output logic [HASH_LEN:0]   occupancy_o
);
    localparam int NBEATS = (KEY_W + BUS_W - 1) / BUS_W;
    localparam int DEPTH  = 1 << HASH_LEN;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int PW     = $clog2(MAX_PROBE + 1);
    localparam int NSLICE = (KEY_W + HASH_LEN - 1) / HASH_LEN;
    localparam int PAD    = NBEATS * BUS_W - KEY_W;

    localparam logic [1:0] RECV  = 2'd0;
    localparam logic [1:0] PROBE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam logic [1:0] ST_HIT      = 2'd0;
    localparam logic [1:0] ST_NEW      = 2'd1;
    localparam logic [1:0] ST_FULL     = 2'd2;
    localparam logic [1:0] ST_NOTFOUND = 2'd3;

    logic [1:0]                state;
    logic [BW-1:0]             beat_cnt;
    logic [KEY_W-1:0]          key_q;
    logic [NBEATS*BUS_W-1:0]   kbuf_nxt;
    logic                      op_q;
    logic [HASH_LEN-1:0]       h_q, idx, tomb_idx;
    logic [PW-1:0]             pcnt;
    logic                      primed, tomb_seen;
    logic [HASH_LEN-1:0]       res_id_q;
    logic [1:0]                res_st_q;
    logic [HASH_LEN:0]         occ;

    logic [KEY_W-1:0]          slot_key [DEPTH];
    logic [DEPTH-1:0]          live, tomb;

    // XOR-fold of the whole key into HASH_LEN bits, top slice zero-padded
    function automatic logic [HASH_LEN-1:0] fold(input logic [KEY_W-1:0] k);
        logic [NSLICE*HASH_LEN-1:0] p;
        logic [HASH_LEN-1:0]        h;
        p = '0;
        p[KEY_W-1:0] = k;
        h = '0;
        for (int s = 0; s < NSLICE; s++) h ^= p[s*HASH_LEN +: HASH_LEN];
        return h;
    endfunction

    always_comb begin
        kbuf_nxt = '0;
        kbuf_nxt[KEY_W-1:0] = key_q;
        kbuf_nxt[beat_cnt*BUS_W +: BUS_W] = tuple_data_i;
    end

    generate
        if (PAD > 0) begin : g_pad
            logic [PAD-1:0] pad_unused;
            assign pad_unused = kbuf_nxt[NBEATS*BUS_W-1:KEY_W];
        end
    endgenerate

    logic                 cur_live, cur_tomb, match, last, empty;
    logic [HASH_LEN-1:0]  first_tomb;
    logic                 resolve, do_ins, do_del;
    logic [HASH_LEN-1:0]  res_id;
    logic [1:0]           res_st;

    assign cur_live   = live[idx];
    assign cur_tomb   = tomb[idx];
    assign match      = cur_live && (slot_key[idx] == key_q);
    assign empty      = !cur_live && !cur_tomb;
    assign last       = (pcnt == PW'(MAX_PROBE - 1));
    assign first_tomb = tomb_seen ? tomb_idx : idx;

    // Resolution of the slot under the probe pointer
    always_comb begin
        resolve = 1'b0;
        do_ins  = 1'b0;
        do_del  = 1'b0;
        res_id  = idx;
        res_st  = ST_HIT;
        if (state == PROBE && primed) begin
            if (!op_q) begin
                if (match) begin
                    resolve = 1'b1;
                end else if (empty || (last && (tomb_seen || cur_tomb))) begin
                    resolve = 1'b1;
                    do_ins  = 1'b1;
                    res_st  = ST_NEW;
                    res_id  = first_tomb;
                end else if (last) begin
                    resolve = 1'b1;
                    res_st  = ST_FULL;
                    res_id  = h_q;
                end
            end else begin
                if (match) begin
                    resolve = 1'b1;
                    do_del  = 1'b1;
                end else if (empty || last) begin
                    resolve = 1'b1;
                    res_st  = ST_NOTFOUND;
                    res_id  = h_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RECV;
            beat_cnt  <= '0;
            key_q     <= '0;
            op_q      <= 1'b0;
            h_q       <= '0;
            idx       <= '0;
            pcnt      <= '0;
            primed    <= 1'b0;
            tomb_seen <= 1'b0;
            tomb_idx  <= '0;
            res_id_q  <= '0;
            res_st_q  <= ST_HIT;
            occ       <= '0;
        end else begin
            case (state)
                RECV: if (tuple_valid_i) begin
                    key_q <= kbuf_nxt[KEY_W-1:0];
                    if (beat_cnt == '0) op_q <= tuple_op_i;
                    if (beat_cnt == BW'(NBEATS - 1)) begin
                        beat_cnt  <= '0;
                        h_q       <= fold(kbuf_nxt[KEY_W-1:0]);
                        state     <= PROBE;
                        primed    <= 1'b0;
                        pcnt      <= '0;
                        tomb_seen <= 1'b0;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                PROBE: begin
                    // First PROBE cycle only loads the probe pointer from the registered hash
                    if (!primed) begin
                        idx    <= h_q;
                        primed <= 1'b1;
                    end else if (resolve) begin
                        res_id_q <= res_id;
                        res_st_q <= res_st;
                        state    <= RESP;
                        if (do_ins && occ < (HASH_LEN+1)'(DEPTH)) occ <= occ + 1'b1;
                        if (do_del && occ != '0) occ <= occ - 1'b1;
                    end else begin
                        if (cur_tomb && !tomb_seen) begin
                            tomb_seen <= 1'b1;
                            tomb_idx  <= idx;
                        end
                        idx  <= idx + 1'b1;
                        pcnt <= pcnt + 1'b1;
                    end
                end
                RESP: if (conn_ready_i) state <= RECV;
                default: state <= RECV;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live <= '0;
            tomb <= '0;
        end else if (resolve) begin
            if (do_ins) begin
                live[first_tomb] <= 1'b1;
                tomb[first_tomb] <= 1'b0;
            end
            if (do_del) begin
                live[idx] <= 1'b0;
                tomb[idx] <= 1'b1;
            end
        end
    end

    // Key storage carries no reset; emptiness is defined by the flags alone
    always_ff @(posedge clk) begin
        if (resolve && do_ins) slot_key[first_tomb] <= key_q;
    end

    assign tuple_ready_o = (state == RECV);
    assign conn_valid_o  = (state == RESP);
    assign conn_data_o   = BUS_W'(res_id_q);
    assign conn_status_o = res_st_q;
    assign occupancy_o   = occ;

endmodule

// File: tb/tb_nat_conn_table.sv
// Directed bench for nat_conn_table: default table (u0) plus a 16-entry, 4-probe table (u1).
module tb_nat_conn_table;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [31:0] data = '0;
    logic        op = 1'b0;
    logic        cready = 1'b0;

    logic        r0, cv0, r1, cv1;
    logic [31:0] cd0, cd1;
    logic [1:0]  cs0, cs1;
    logic [10:0] oc0;
    logic [4:0]  oc1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nat_conn_table u0 (
        .clk(clk), .rst(rst), .tuple_valid_i(v0), .tuple_data_i(data), .tuple_op_i(op),
        .tuple_ready_o(r0), .conn_valid_o(cv0), .conn_data_o(cd0), .conn_status_o(cs0),
        .conn_ready_i(cready), .occupancy_o(oc0)
    );

    nat_conn_table #(.HASH_LEN(4), .MAX_PROBE(4)) u1 (
        .clk(clk), .rst(rst), .tuple_valid_i(v1), .tuple_data_i(data), .tuple_op_i(op),
        .tuple_ready_o(r1), .conn_valid_o(cv1), .conn_data_o(cd1), .conn_status_o(cs1),
        .conn_ready_i(cready), .occupancy_o(oc1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int d, input logic [127:0] k, input logic o, input int nb);
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            if (d == 0) v0 = 1'b1; else v1 = 1'b1;
            data = k[b*32 +: 32];
            op   = o;
            @(posedge clk);
        end
        @(negedge clk);
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    // Waits for the response (bounded), checks it, completes the handshake
    task automatic do_op(input string tag, input int d, input logic [127:0] k, input logic o,
                         input logic [1:0] est, input int eid, input int eocc, input int elat);
        int   lat;
        logic got;
        send(d, k, o, 4);
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk); #1;
            lat++;
            if ((d == 0) ? cv0 : cv1) got = 1'b1;
        end
        chk({tag, "_valid"}, 64'(got), 64'd1);
        if (elat > 0) chk({tag, "_lat"}, 64'(lat), 64'(elat));
        chk({tag, "_status"}, 64'((d == 0) ? cs0 : cs1), 64'(est));
        chk({tag, "_id"}, 64'((d == 0) ? cd0 : cd1), 64'(eid));
        chk({tag, "_occ"}, (d == 0) ? 64'(oc0) : 64'(oc1), 64'(eocc));
        @(negedge clk); cready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_drop"}, 64'((d == 0) ? cv0 : cv1), 64'd0);
        @(negedge clk); cready = 1'b0;
    endtask

    localparam logic [1:0] HIT = 2'd0, NEW = 2'd1, FULL = 2'd2, NF = 2'd3;

    initial begin
        logic got;
        #12;
        chk("rst_ready", 64'(r0), 64'd1);
        chk("rst_valid", 64'(cv0), 64'd0);
        chk("rst_data", 64'(cd0), 64'd0);
        chk("rst_status", 64'(cs0), 64'd0);
        chk("rst_occ", 64'(oc0), 64'd0);
        @(negedge clk); rst = 1'b0;

        do_op("insA", 0, 128'h5, 1'b0, NEW, 5, 1, 2);
        do_op("hitA", 0, 128'h5, 1'b0, HIT, 5, 1, 2);
        do_op("insB", 0, 128'h404, 1'b0, NEW, 6, 2, 3);
        do_op("delA", 0, 128'h5, 1'b1, HIT, 5, 1, 2);
        do_op("hitB", 0, 128'h404, 1'b0, HIT, 6, 1, 3);
        do_op("insC", 0, 128'h100405, 1'b0, NEW, 5, 2, 4);
        do_op("delX", 0, 128'h7, 1'b1, NF, 7, 2, 2);

        // Wrap-around and full on the small table
        do_op("w14", 1, 128'hE, 1'b0, NEW, 14, 1, 2);
        do_op("w15", 1, 128'hE0, 1'b0, NEW, 15, 2, 3);
        do_op("w0", 1, 128'hE00, 1'b0, NEW, 0, 3, 4);
        do_op("w1", 1, 128'hE000, 1'b0, NEW, 1, 4, 5);
        do_op("full", 1, 128'hE0000, 1'b0, FULL, 14, 4, 5);

        // Back-pressure: response held for 5 cycles
        send(0, 128'h100405, 1'b0, 4);
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk); #1;
            if (cv0) got = 1'b1;
        end
        chk("bp_valid", 64'(got), 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 64'(cv0), 64'd1);
            chk("bp_hold_id", 64'(cd0), 64'd5);
            chk("bp_hold_status", 64'(cs0), 64'(HIT));
            chk("bp_hold_ready", 64'(r0), 64'd0);
        end
        @(negedge clk); cready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_valid", 64'(cv0), 64'd0);
        chk("bp_rel_ready", 64'(r0), 64'd1);
        @(negedge clk); cready = 1'b0;
        @(posedge clk); #1;
        chk("bp_single", 64'(cv0), 64'd0);

        // Reset after two of four beats
        send(0, 128'h5, 1'b0, 2);
        rst = 1'b1;
        #1;
        chk("mrst_ready", 64'(r0), 64'd1);
        chk("mrst_valid", 64'(cv0), 64'd0);
        chk("mrst_data", 64'(cd0), 64'd0);
        chk("mrst_status", 64'(cs0), 64'd0);
        chk("mrst_occ", 64'(oc0), 64'd0);
        @(negedge clk); rst = 1'b0;
        do_op("postrst", 0, 128'h5, 1'b0, NEW, 5, 1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
